// File: rtl/lcd_status_display_if.sv
// Bundle between the lcd_fsm status producer, the LCD pins and lcd_status_display.
// The slave modport is the display controller; the master modport is the status
// producer plus the LCD side.
interface lcd_status_display_if;
  // Status fields produced by lcd_fsm
  logic [1:0] music;
  logic [1:0] speed;
  logic       mode;
  logic [2:0] volume;

  // HD44780 pins and controller status
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       init_done;
  logic       busy;

  modport master (
    output music, speed, mode, volume,
    input  lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, busy
  );

  modport slave (
    input  music, speed, mode, volume,
    output lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, busy
  );
endinterface

// File: rtl/lcd_status_display.sv
// HD44780 16x2 status display driver (8-bit bus, write-only).
// Runs the power-up init sequence, then rewrites both lines from a snapshot
// of the status fields whenever any field changes.
module lcd_status_display #(
  parameter int unsigned PWR_WAIT = 750000,
  parameter int unsigned EN_HIGH  = 25,
  parameter int unsigned CMD_WAIT = 2500,
  parameter int unsigned CLR_WAIT = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_status_display_if.slave  io_lcd
);

  typedef enum logic [1:0] {ST_PWR, ST_INIT, ST_IDLE, ST_REFRESH} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_HOLD} phase_t;

  typedef struct packed {
    logic [1:0] music;
    logic [1:0] speed;
    logic       mode;
    logic [2:0] volume;
  } status_t;

  localparam logic [5:0] INIT_LAST    = 6'd3;   // 0x38, 0x0C, 0x06, 0x01
  localparam logic [5:0] REFRESH_LAST = 6'd33;  // 0x80 + 16 chars + 0xC0 + 16 chars

  // Registers
  state_t      r_state;
  phase_t      r_phase;
  logic [31:0] r_cnt;
  logic [5:0]  r_idx;
  status_t     r_snap;
  logic        r_dirty;
  logic        r_rs;
  logic        r_en;
  logic [7:0]  r_data;
  logic        r_init_done;
  logic        r_busy;

  // Next-state wires
  state_t      w_state_nxt;
  phase_t      w_phase_nxt;
  logic [31:0] w_cnt_nxt;
  logic [5:0]  w_idx_nxt;
  status_t     w_snap_nxt;
  logic        w_dirty_nxt;
  logic        w_rs_nxt;
  logic        w_en_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_init_done_nxt;
  logic        w_load;
  logic        w_last;
  logic [31:0] w_hold_len;
  status_t     w_inputs;

  assign w_inputs = {io_lcd.music, io_lcd.speed, io_lcd.mode, io_lcd.volume};

  // Line 1: "SONG:n SPD:n    "
  function automatic logic [7:0] line1_char(input logic [3:0] pos, input status_t s);
    logic [7:0] c;
    case (pos)
      4'd0:    c = 8'h53;                      // S
      4'd1:    c = 8'h4F;                      // O
      4'd2:    c = 8'h4E;                      // N
      4'd3:    c = 8'h47;                      // G
      4'd4:    c = 8'h3A;                      // :
      4'd5:    c = 8'h31 + {6'd0, s.music};
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h53;                      // S
      4'd8:    c = 8'h50;                      // P
      4'd9:    c = 8'h44;                      // D
      4'd10:   c = 8'h3A;                      // :
      4'd11:   c = 8'h31 + {6'd0, s.speed};
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  // Line 2: "MODE:c VOL:n    "
  function automatic logic [7:0] line2_char(input logic [3:0] pos, input status_t s);
    logic [7:0] c;
    case (pos)
      4'd0:    c = 8'h4D;                      // M
      4'd1:    c = 8'h4F;                      // O
      4'd2:    c = 8'h44;                      // D
      4'd3:    c = 8'h45;                      // E
      4'd4:    c = 8'h3A;                      // :
      4'd5:    c = s.mode ? 8'h4C : 8'h53;     // L / S
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h56;                      // V
      4'd8:    c = 8'h4F;                      // O
      4'd9:    c = 8'h4C;                      // L
      4'd10:   c = 8'h3A;                      // :
      4'd11:   c = 8'h30 + {5'd0, s.volume};
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  // {rs, data} for byte idx of the given sequence; characters come only from the snapshot.
  function automatic logic [8:0] byte_for(input state_t st, input logic [5:0] idx, input status_t s);
    logic [8:0] b;
    if (st == ST_INIT) begin
      case (idx[1:0])
        2'd0:    b = {1'b0, 8'h38};            // 8-bit bus, 2 lines, 5x8 font
        2'd1:    b = {1'b0, 8'h0C};            // display on, cursor off
        2'd2:    b = {1'b0, 8'h06};            // entry mode: increment
        default: b = {1'b0, 8'h01};            // clear
      endcase
    end else if (idx == 6'd0) begin
      b = {1'b0, 8'h80};                       // DDRAM line 1
    end else if (idx == 6'd17) begin
      b = {1'b0, 8'hC0};                       // DDRAM line 2
    end else if (idx < 6'd17) begin
      b = {1'b1, line1_char(idx[3:0] - 4'd1, s)};
    end else begin
      b = {1'b1, line2_char(idx[3:0] - 4'd2, s)};
    end
    return b;
  endfunction

  // The clear command needs a much longer settle time than the others.
  assign w_hold_len = (!r_rs && r_data == 8'h01) ? CLR_WAIT : CMD_WAIT;
  assign w_last     = (r_state == ST_INIT) ? (r_idx == INIT_LAST) : (r_idx == REFRESH_LAST);

  // Next-state and next-output logic for the top FSM and its per-byte sub-phases.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_snap_nxt      = r_snap;
    w_dirty_nxt     = r_dirty;
    w_rs_nxt        = r_rs;
    w_en_nxt        = r_en;
    w_data_nxt      = r_data;
    w_init_done_nxt = r_init_done;
    w_load          = 1'b0;

    case (r_state)
      ST_PWR: begin
        if (r_cnt == PWR_WAIT) begin
          w_state_nxt = ST_INIT;
          w_phase_nxt = PH_SETUP;
          w_idx_nxt   = 6'd0;
          w_cnt_nxt   = 32'd0;
          w_load      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      ST_INIT, ST_REFRESH: begin
        case (r_phase)
          PH_SETUP: begin
            w_phase_nxt = PH_EN;
            w_en_nxt    = 1'b1;
            w_cnt_nxt   = 32'd0;
          end
          PH_EN: begin
            if (r_cnt == EN_HIGH - 1) begin
              w_phase_nxt = PH_HOLD;
              w_en_nxt    = 1'b0;
              w_cnt_nxt   = 32'd0;
            end else begin
              w_cnt_nxt = r_cnt + 32'd1;
            end
          end
          PH_HOLD: begin
            if (r_cnt == w_hold_len - 32'd1) begin
              w_cnt_nxt = 32'd0;
              if (w_last) begin
                if (r_state == ST_INIT) w_init_done_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
              end else begin
                w_idx_nxt   = r_idx + 6'd1;
                w_phase_nxt = PH_SETUP;
                w_load      = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + 32'd1;
            end
          end
          default: w_phase_nxt = PH_SETUP;
        endcase
      end

      ST_IDLE: begin
        if (w_inputs != r_snap || r_dirty) begin
          w_snap_nxt  = w_inputs;
          w_dirty_nxt = 1'b0;
          w_state_nxt = ST_REFRESH;
          w_phase_nxt = PH_SETUP;
          w_idx_nxt   = 6'd0;
          w_cnt_nxt   = 32'd0;
          w_load      = 1'b1;
        end
      end

      default: w_state_nxt = ST_PWR;
    endcase

    // Entering SETUP: present the next byte on the bus with lcd_en still low.
    if (w_load) begin
      {w_rs_nxt, w_data_nxt} = byte_for(w_state_nxt, w_idx_nxt, w_snap_nxt);
    end
  end

  // State and registered outputs; synchronous reset aborts any transfer and restarts at PWR.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state     <= ST_PWR;
      r_phase     <= PH_SETUP;
      r_cnt       <= 32'd0;
      r_idx       <= 6'd0;
      r_snap      <= '0;
      r_dirty     <= 1'b1;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_data      <= 8'h00;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_snap      <= w_snap_nxt;
      r_dirty     <= w_dirty_nxt;
      r_rs        <= w_rs_nxt;
      r_en        <= w_en_nxt;
      r_data      <= w_data_nxt;
      r_init_done <= w_init_done_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign io_lcd.lcd_rs    = r_rs;
  assign io_lcd.lcd_rw    = 1'b0;
  assign io_lcd.lcd_en    = r_en;
  assign io_lcd.lcd_data  = r_data;
  assign io_lcd.init_done = r_init_done;
  assign io_lcd.busy      = r_busy;

endmodule
